// File: rtl/int_issue_queue.sv
// Integer issue queue: buffers micro-ops, issues one per cycle to INT_EXEC,
// and registers the result as a writeback request.
//
// Ports:
//   clk_in, rst_in (async active-low), flush_in (sync)
//   enq_*      : decode-side valid/ready entry input {uop, a, b, rd}
//   exec_*     : head entry and issue strobe to INT_EXEC, result back in
//   wb_*       : registered writeback request, held under wb_stall_in
//   occupancy_out : number of queued, not yet issued entries
module int_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int RD_WIDTH = 5
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       flush_in,
    input  logic                       enq_valid_in,
    output logic                       enq_ready_out,
    input  logic [3:0]                 enq_uop_in,
    input  logic [31:0]                enq_a_data_in,
    input  logic [31:0]                enq_b_data_in,
    input  logic [RD_WIDTH-1:0]        enq_rd_in,
    output logic                       exec_enable_out,
    output logic [3:0]                 exec_uop_out,
    output logic [31:0]                exec_a_data_out,
    output logic [31:0]                exec_b_data_out,
    input  logic [31:0]                exec_res_data_in,
    output logic                       wb_valid_out,
    output logic [RD_WIDTH-1:0]        wb_rd_out,
    output logic [31:0]                wb_data_out,
    input  logic                       wb_stall_in,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_out
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [3:0]          uop;
        logic [31:0]         a;
        logic [31:0]         b;
        logic [RD_WIDTH-1:0] rd;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head_e;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          empty;
    logic          wb_hold;
    logic          enq_fire;
    logic          iss_fire;

    assign empty         = (count == '0);
    // Ready is based on the registered count only; no same-cycle dequeue look-ahead.
    assign enq_ready_out = (count < CW'(DEPTH));
    assign wb_hold       = wb_valid_out & wb_stall_in;
    assign enq_fire      = enq_valid_in & enq_ready_out & ~flush_in;
    assign iss_fire      = ~empty & ~wb_hold & ~flush_in;

    // Empty queue drives zeros so INT_EXEC never sees stale entry contents.
    assign head_e = empty ? '0 : mem[head];

    assign exec_enable_out = iss_fire;
    assign exec_uop_out    = head_e.uop;
    assign exec_a_data_out = head_e.a;
    assign exec_b_data_out = head_e.b;
    assign occupancy_out   = count;

    // Entry storage carries no reset; contents are only read when count != 0.
    always_ff @(posedge clk_in) begin
        if (enq_fire) begin
            mem[tail] <= '{
                uop: enq_uop_in,
                a:   enq_a_data_in,
                b:   enq_b_data_in,
                rd:  enq_rd_in
            };
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PW'(1);
            end
            if (iss_fire) begin
                head <= head + PW'(1);
            end
            case ({enq_fire, iss_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wb_valid_out <= 1'b0;
            wb_rd_out    <= '0;
            wb_data_out  <= '0;
        end else if (flush_in) begin
            wb_valid_out <= 1'b0;
        end else if (iss_fire) begin
            wb_valid_out <= 1'b1;
            wb_rd_out    <= head_e.rd;
            wb_data_out  <= exec_res_data_in;
        end else if (!wb_hold) begin
            wb_valid_out <= 1'b0;
        end
    end

endmodule
